// File: rtl/logic_gate_pipe_if.sv
// Handshake bundle for logic_gate_pipe: an operand channel into the block and a
// result channel out of it. The master side is the surrounding logic (source of
// operands, sink of results); the slave side is the gate pipe itself.
//
// Valid/ready rule for both channels: a transfer happens on a rising clock edge
// where valid && ready are both 1. Once valid is raised, the sender holds valid
// and its payload stable until that transfer. The receiver is free to raise or
// lower ready at any time.
interface logic_gate_pipe_if #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 2
);
  // operand channel
  logic                  in_valid;
  logic                  in_ready;
  logic [N_IN*WIDTH-1:0] in_data;
  logic [2:0]            in_op;
  // result channel
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_y;
  logic                  out_all;
  logic                  out_any;

  modport master (
    output in_valid, in_data, in_op, out_ready,
    input  in_ready, out_valid, out_y, out_all, out_any
  );

  modport slave (
    input  in_valid, in_data, in_op, out_ready,
    output in_ready, out_valid, out_y, out_all, out_any
  );
endinterface

// File: rtl/logic_gate_pipe.sv
// Registered N-operand bitwise logic unit. Each accepted operand set is reduced
// by the selected function and queued in a 2-entry FIFO, so upstream can keep
// streaming while downstream applies backpressure. A saturating counter tracks
// how many results have been taken.
module logic_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  logic_gate_pipe_if.slave pipe,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  logic [WIDTH-1:0] operand0;
  logic [WIDTH-1:0] red_and;
  logic [WIDTH-1:0] red_or;
  logic [WIDTH-1:0] red_xor;
  logic [WIDTH-1:0] result;

  // Two storage slots addressed by 1-bit pointers; fill counts 0..2.
  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       fill;
  logic [WIDTH-1:0] head;
  logic             push;
  logic             pop;

  assign operand0 = pipe.in_data[WIDTH-1:0];

  // Fold all operands through AND/OR/XOR; with one operand each fold is operand0.
  always_comb begin
    red_and = operand0;
    red_or  = operand0;
    red_xor = operand0;
    for (int k = 1; k < N_IN; k++) begin
      red_and = red_and & pipe.in_data[k*WIDTH +: WIDTH];
      red_or  = red_or  | pipe.in_data[k*WIDTH +: WIDTH];
      red_xor = red_xor ^ pipe.in_data[k*WIDTH +: WIDTH];
    end
  end

  // Select the requested function; the inverted forms reuse the plain folds.
  always_comb begin
    result = operand0;
    case (op_e'(pipe.in_op))
      OP_AND:  result = red_and;
      OP_OR:   result = red_or;
      OP_XOR:  result = red_xor;
      OP_NAND: result = ~red_and;
      OP_NOR:  result = ~red_or;
      OP_XNOR: result = ~red_xor;
      OP_NOT:  result = ~operand0;
      default: result = operand0;
    endcase
  end

  // Ready depends only on registered occupancy, never on out_ready, so a slot
  // freed by a pop is offered to upstream one cycle later.
  assign pipe.in_ready  = (fill != 2'd2);
  assign pipe.out_valid = (fill != 2'd0);
  assign push = pipe.in_valid && pipe.in_ready;
  assign pop  = pipe.out_valid && pipe.out_ready;

  // Outputs are gated to zero when empty so no stale slot content leaks out.
  assign head          = mem[rd_ptr];
  assign pipe.out_y    = pipe.out_valid ? head : '0;
  assign pipe.out_all  = pipe.out_valid & (&head);
  assign pipe.out_any  = pipe.out_valid & (|head);

  // FIFO storage, pointers and occupancy; push and pop may share an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      fill   <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= result;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   fill <= fill + 2'd1;
        2'b01:   fill <= fill - 2'd1;
        default: fill <= fill;
      endcase
    end
  end

  // Count taken results, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (pop && (op_count != {CNT_W{1'b1}})) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule
